// File: rtl/hazard_ctrl.sv
// Hazard controller: EX operand forwarding, load-use interlock,
// mul/div busy scoreboard and branch flush gating.
module hazard_ctrl #(
    parameter  int REG_W      = 5,
    parameter  int STAGES     = 2,
    parameter  int LOAD_STALL = 1,
    parameter  int MD_LAT     = 32,
    localparam int FW         = $clog2(STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REG_W-1:0]        ex_rs,
    input  logic [REG_W-1:0]        ex_rt,
    input  logic [STAGES*REG_W-1:0] stg_rd,
    input  logic [STAGES-1:0]       stg_we,
    input  logic [REG_W-1:0]        id_rs,
    input  logic [REG_W-1:0]        id_rt,
    input  logic                    id_use_rs,
    input  logic                    id_use_rt,
    input  logic [REG_W-1:0]        ex_rd,
    input  logic                    ex_load,
    input  logic                    id_md_start,
    input  logic                    id_md_use,
    input  logic                    branch_taken,
    output logic [FW-1:0]           fwd_a,
    output logic [FW-1:0]           fwd_b,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    bubble_ex,
    output logic                    flush_id,
    output logic                    md_busy
);

    localparam int LW = $clog2(LOAD_STALL + 1);
    localparam int MW = $clog2(MD_LAT + 1);

    typedef enum logic [0:0] {
        RUN,
        LD_WAIT
    } state_t;

    state_t          state, state_n;
    logic [LW-1:0]   ld_cnt, ld_cnt_n;
    logic [MW-1:0]   md_cnt, md_cnt_n;
    logic            ld_hit, ld_stall, md_stall, stall;
    logic [REG_W-1:0] rd;

    // Scan far-to-near so the nearest matching stage wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        rd    = '0;
        for (int k = STAGES; k >= 1; k--) begin
            rd = stg_rd[(k-1)*REG_W +: REG_W];
            if (stg_we[k-1] && rd != '0 && rd == ex_rs)
                fwd_a = FW'(k);
            if (stg_we[k-1] && rd != '0 && rd == ex_rt)
                fwd_b = FW'(k);
        end
    end

    assign ld_hit = ex_load && ex_rd != '0 &&
                    ((id_use_rs && id_rs == ex_rd) ||
                     (id_use_rt && id_rt == ex_rd));

    always_comb begin
        state_n  = state;
        ld_cnt_n = ld_cnt;
        ld_stall = 1'b0;
        unique case (state)
            RUN: begin
                ld_stall = ld_hit;
                if (ld_hit && LOAD_STALL > 1) begin
                    state_n  = LD_WAIT;
                    ld_cnt_n = LW'(LOAD_STALL - 1);
                end
            end
            LD_WAIT: begin
                ld_stall = 1'b1;
                ld_cnt_n = ld_cnt - LW'(1);
                if (ld_cnt == LW'(1))
                    state_n = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    assign md_busy  = md_cnt != '0;
    assign md_stall = id_md_use && md_busy;
    assign stall    = ld_stall || md_stall;

    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;
    assign flush_id  = branch_taken && !stall;

    // A start held off by a stall is not accepted, so no reload while busy.
    always_comb begin
        md_cnt_n = md_cnt;
        if (id_md_start && !stall_id)
            md_cnt_n = MW'(MD_LAT);
        else if (md_busy)
            md_cnt_n = md_cnt - MW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            ld_cnt <= '0;
            md_cnt <= '0;
        end else begin
            state  <= state_n;
            ld_cnt <= ld_cnt_n;
            md_cnt <= md_cnt_n;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with LOAD_STALL=2, MD_LAT=4.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ex_rs, ex_rt, id_rs, id_rt, ex_rd;
    logic [9:0] stg_rd;
    logic [1:0] stg_we;
    logic       id_use_rs, id_use_rt, ex_load;
    logic       id_md_start, id_md_use, branch_taken;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_if, stall_id, bubble_ex, flush_id, md_busy;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(
        .REG_W(5), .STAGES(2), .LOAD_STALL(2), .MD_LAT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .stg_rd(stg_rd), .stg_we(stg_we),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_load(ex_load),
        .id_md_start(id_md_start), .id_md_use(id_md_use),
        .branch_taken(branch_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush_id(flush_id),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ld();
        ex_load   = 1'b0;
        ex_rd     = '0;
        id_rs     = '0;
        id_rt     = '0;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
    endtask

    task automatic set_ld();
        ex_load   = 1'b1;
        ex_rd     = 5'd5;
        id_rt     = 5'd5;
        id_use_rt = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_rs = '0; ex_rt = '0; stg_rd = '0; stg_we = '0;
        clear_ld();
        id_md_start = 1'b0; id_md_use = 1'b0; branch_taken = 1'b0;
        #2;
        check("rst_busy", md_busy, 0);
        check("rst_stall", stall_if, 0);
        check("rst_fwd", fwd_a, 0);
        #5 rst_n = 1'b1;
        step();

        // forwarding priority
        ex_rs = 5'd8; ex_rt = 5'd8; stg_rd = {5'd8, 5'd8}; stg_we = 2'b11;
        #1;
        check("fwd_near_a", fwd_a, 1);
        check("fwd_near_b", fwd_b, 1);
        stg_we = 2'b10;
        #1;
        check("fwd_far_a", fwd_a, 2);
        ex_rs = 5'd0; stg_rd = {5'd0, 5'd0}; stg_we = 2'b11;
        #1;
        check("fwd_r0", fwd_a, 0);
        ex_rt = 5'd3; stg_rd = {5'd3, 5'd4};
        #1;
        check("fwd_b_far", fwd_b, 2);
        stg_we = 2'b00;
        #1;
        check("fwd_we_off", fwd_b, 0);

        // load-use: two bubbles, load leaves EX after the first
        step();
        set_ld();
        #1;
        check("ld_c1_if", stall_if, 1);
        check("ld_c1_id", stall_id, 1);
        check("ld_c1_bub", bubble_ex, 1);
        step();
        ex_load = 1'b0;
        #1;
        check("ld_c2", stall_if, 1);
        step();
        check("ld_c3", stall_if, 0);
        set_ld();
        id_use_rt = 1'b0;
        #1;
        check("ld_nouse", stall_if, 0);
        ex_rd = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
        #1;
        check("ld_r0", stall_if, 0);
        clear_ld();

        // mul/div
        step();
        id_md_start = 1'b1; id_md_use = 1'b1;
        #1;
        check("md_issue", stall_if, 0);
        step();
        id_md_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("md_busy%0d", i), md_busy, 1);
            check($sformatf("md_stall%0d", i), bubble_ex, 1);
            step();
        end
        #1;
        check("md_rel", stall_if, 0);
        id_md_start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("md2_stall%0d", i), stall_id, 1);
            step();
        end
        #1;
        check("md2_noreload", md_busy, 0);
        check("md2_rel", stall_id, 0);
        id_md_start = 1'b0; id_md_use = 1'b0;

        // branch under load stall
        step();
        branch_taken = 1'b1;
        set_ld();
        #1;
        check("br_stall1", flush_id, 0);
        step();
        ex_load = 1'b0;
        #1;
        check("br_stall2", flush_id, 0);
        step();
        check("br_release", flush_id, 1);
        branch_taken = 1'b0;
        clear_ld();

        // reset during LD_WAIT with md_cnt=3
        step();
        id_md_start = 1'b1; id_md_use = 1'b1;
        step();
        id_md_start = 1'b0; id_md_use = 1'b0;
        set_ld();
        step();
        clear_ld();
        #1;
        check("pre_rst_stall", stall_if, 1);
        check("pre_rst_busy", md_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", md_busy, 0);
        check("mid_rst_stall", stall_if, 0);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_stall", stall_if, 0);
        check("post_rst_busy", md_busy, 0);
        check("post_rst_flush", flush_id, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
